// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an N-way input mux: walks sel, captures each channel into a
// snapshot, then offers it on a valid/ready handshake. Optional MUX_SCAN_DIFF_EN adds diff_mask.
module mux_scan_ctrl #(
  parameter int NUM_INP = 31,
  parameter int SEL_W   = 5,
  parameter int DATA_W  = 2,
  parameter int SETTLE  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [DATA_W-1:0]         mux_out,
  output logic [SEL_W-1:0]          sel,
  output logic                      busy,
  output logic                      snap_valid,
  input  logic                      snap_ready,
`ifdef MUX_SCAN_DIFF_EN
  output logic [NUM_INP*DATA_W-1:0] snap_data,
  output logic [NUM_INP-1:0]        diff_mask
`else
  output logic [NUM_INP*DATA_W-1:0] snap_data
`endif
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(NUM_INP - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    r_state;
  logic [SEL_W-1:0]          r_sel;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_busy;
  logic                      r_valid;
  logic [NUM_INP*DATA_W-1:0] r_snap;
`ifdef MUX_SCAN_DIFF_EN
  logic [NUM_INP*DATA_W-1:0] r_prev;
`endif

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_snap  <= '0;
`ifdef MUX_SCAN_DIFF_EN
      r_prev  <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_state <= SCAN;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (abort) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == SETTLE_LAST) begin
            // Mux output has settled for SETTLE cycles: latch it into this channel's slot.
            for (int i = 0; i < NUM_INP; i++) begin
              if (r_sel == SEL_W'(i)) r_snap[i*DATA_W +: DATA_W] <= mux_out;
            end
            r_cnt <= '0;
            if (r_sel == LAST_CH) begin
              r_sel   <= '0;
              r_valid <= 1'b1;
              r_state <= DONE;
            end else begin
              r_sel <= r_sel + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (snap_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
`ifdef MUX_SCAN_DIFF_EN
            r_prev  <= r_snap;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sel        = r_sel;
  assign busy       = r_busy;
  assign snap_valid = r_valid;
  assign snap_data  = r_snap;

`ifdef MUX_SCAN_DIFF_EN
  logic [NUM_INP-1:0] w_diff;
  always_comb begin
    w_diff = '0;
    for (int i = 0; i < NUM_INP; i++) begin
      w_diff[i] = (r_snap[i*DATA_W +: DATA_W] != r_prev[i*DATA_W +: DATA_W]);
    end
  end
  assign diff_mask = w_diff;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: default instance plus a SETTLE=3 instance,
// table-driven scans with a snapshot scoreboard and hand-written abort/reset sequences.
module tb_mux_scan_ctrl;

  localparam int N = 31;
  localparam int SW = 5;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, ready;
  logic          start2, ready2;
  logic [DW-1:0] mux_out, mux_out2;
  logic [SW-1:0] sel, sel2;
  logic          busy, busy2, valid, valid2;
  logic [N*DW-1:0] data, data2;
`ifdef MUX_SCAN_DIFF_EN
  logic [N-1:0]  dmask, dmask2;
`endif

  logic [DW-1:0] ch_val [N];

  int n_tests = 0;
  int n_fail  = 0;
  logic [N*DW-1:0] exp_q [$];
  logic [N*DW-1:0] prev0 = '0;

  always #5 clk = ~clk;

  always_comb mux_out  = (int'(sel)  < N) ? ch_val[sel]  : '0;
  always_comb mux_out2 = (int'(sel2) < N) ? ch_val[sel2] : '0;

  mux_scan_ctrl #(.NUM_INP(N), .SEL_W(SW), .DATA_W(DW), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mux_out(mux_out),
    .sel(sel), .busy(busy), .snap_valid(valid), .snap_ready(ready),
`ifdef MUX_SCAN_DIFF_EN
    .snap_data(data), .diff_mask(dmask)
`else
    .snap_data(data)
`endif
  );

  mux_scan_ctrl #(.NUM_INP(N), .SEL_W(SW), .DATA_W(DW), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .mux_out(mux_out2),
    .sel(sel2), .busy(busy2), .snap_valid(valid2), .snap_ready(ready2),
`ifdef MUX_SCAN_DIFF_EN
    .snap_data(data2), .diff_mask(dmask2)
`else
    .snap_data(data2)
`endif
  );

  typedef struct {
    int pat;         // channel value pattern
    int ready_dly;   // cycles of backpressure after valid
    bit pulse;       // pulse start/abort during backpressure
    int exp_lat;     // expected edges from accept to valid
  } vec_t;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat_val(input int pat, input int i);
    case (pat)
      0:       return DW'(i % 4);
      1:       return 2'd3;
      2:       return DW'(3 - (i % 4));
      default: return DW'($urandom_range(3, 0));
    endcase
  endfunction

  function automatic logic [N*DW-1:0] model_snap();
    logic [N*DW-1:0] s = '0;
    for (int i = 0; i < N; i++) s[i*DW +: DW] = ch_val[i];
    return s;
  endfunction

  function automatic logic [N-1:0] model_diff(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) m[i] = (a[i*DW +: DW] != b[i*DW +: DW]);
    return m;
  endfunction

  function automatic int cur_sel(input int d);   return d != 0 ? int'(sel2) : int'(sel); endfunction
  function automatic logic cur_valid(input int d); return d != 0 ? valid2 : valid; endfunction
  function automatic logic cur_busy(input int d);  return d != 0 ? busy2 : busy; endfunction
  function automatic logic [N*DW-1:0] cur_data(input int d); return d != 0 ? data2 : data; endfunction

  task automatic set_pattern(input int pat);
    for (int i = 0; i < N; i++) ch_val[i] = pat_val(pat, i);
  endtask

  task automatic run_scan(input int d, input int settle, input int ready_dly, input bit pulse,
                          input int exp_lat);
    int k, bad, sbad;
    logic [N*DW-1:0] exp;
    exp_q.push_back(model_snap());
    if (d != 0) start2 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start2 = 1'b0;
    k = 0; bad = 0;
    while (!cur_valid(d) && k < 400) begin
      if (cur_sel(d) != k / settle || cur_busy(d) !== 1'b1) bad++;
      tick();
      k++;
    end
    check("latency", 64'(k), 64'(exp_lat));
    check("sel_walk", 64'(bad), 64'd0);
    exp = exp_q.pop_front();
    check("snap_data", 64'(cur_data(d)), 64'(exp));
`ifdef MUX_SCAN_DIFF_EN
    if (d == 0) check("diff_mask", 64'(dmask), 64'(model_diff(exp, prev0)));
`endif
    sbad = 0;
    for (int j = 0; j < ready_dly; j++) begin
      if (pulse && j == 3) start = 1'b1;
      if (pulse && j == 5) abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      if (cur_valid(d) !== 1'b1 || cur_data(d) !== exp || cur_sel(d) != 0) sbad++;
    end
    if (ready_dly > 0) check("hold_stable", 64'(sbad), 64'd0);
    if (d != 0) ready2 = 1'b1; else ready = 1'b1;
    tick();
    ready = 1'b0; ready2 = 1'b0;
    if (d == 0) prev0 = exp;
    check("valid_drop", 64'(cur_valid(d)), 64'd0);
    check("busy_drop", 64'(cur_busy(d)), 64'd0);
    tick();
    check("idle_after", 64'(cur_busy(d)), 64'd0);
  endtask

  task automatic wait_sel(input int v);
    int k = 0;
    while (int'(sel) != v && k < 100) begin
      tick();
      k++;
    end
    check("wait_sel", 64'(sel), 64'(v));
  endtask

  task automatic no_valid_window(input string name);
    int vb = 0;
    for (int j = 0; j < 40; j++) begin
      if (valid !== 1'b0 || busy !== 1'b0) vb++;
      tick();
    end
    check(name, 64'(vb), 64'd0);
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{pat: 0, ready_dly: 0,  pulse: 1'b0, exp_lat: 31};
    vecs[1] = '{pat: 1, ready_dly: 0,  pulse: 1'b0, exp_lat: 31};
    vecs[2] = '{pat: 2, ready_dly: 10, pulse: 1'b1, exp_lat: 31};
    vecs[3] = '{pat: 3, ready_dly: 2,  pulse: 1'b0, exp_lat: 31};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
    start2 = 1'b0; ready2 = 1'b0;
    set_pattern(0);
    repeat (3) tick();
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    rst_n = 1'b1;
    tick();

    // abort=1 alongside start in IDLE must not launch a scan
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_over_start", 64'(busy), 64'd0);

    for (int v = 0; v < 4; v++) begin
      set_pattern(vecs[v].pat);
      run_scan(0, 1, vecs[v].ready_dly, vecs[v].pulse, vecs[v].exp_lat);
    end

    // Abort at channel 12, then a full scan must still complete
    set_pattern(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_sel(12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_sel", 64'(sel), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(valid), 64'd0);
    no_valid_window("abort_quiet");
    set_pattern(0);
    run_scan(0, 1, 0, 1'b0, 31);

    // Reset asserted mid-scan at channel 7 for two edges
    set_pattern(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_sel(7);
    rst_n = 1'b0;
    tick();
    tick();
    check("mrst_sel", 64'(sel), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_valid", 64'(valid), 64'd0);
    check("mrst_data", 64'(data), 64'd0);
    rst_n = 1'b1;
    prev0 = '0;
    no_valid_window("mrst_quiet");

    // SETTLE=3 instance: each sel held 3 cycles, valid at edge 93
    set_pattern(3);
    run_scan(1, 3, 0, 1'b0, 93);

`ifdef MUX_SCAN_DIFF_EN
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    prev0 = '0;
    tick();
    set_pattern(0);
    run_scan(0, 1, 0, 1'b0, 31);
    ch_val[5] = 2'b10;
    exp_q.push_back(model_snap());
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200 && !valid; k++) tick();
    check("diff_valid", 64'(valid), 64'd1);
    check("diff_ch5_only", 64'(dmask), 64'h0000_0020);
    check("diff_data", 64'(data), 64'(exp_q.pop_front()));
    ready = 1'b1;
    tick();
    ready = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
